// File: rtl/ibex_instr_mem_responder_pkg.sv
// Shared bus constants and the per-stage record carried down the fetch response pipeline.
// Latency: n/a. Backpressure: n/a.
package ibex_instr_mem_responder_pkg;

    localparam int unsigned BUS_SIZE = 32;
    localparam int unsigned IDX_W    = BUS_SIZE - 2;

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } instr_rsp_t;

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED(39,32) encoder: appends 7 check bits, XOR-inverted so all-zero words are not codewords.
// Latency: combinational. Backpressure: none.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [6:0] chk;

    always_comb begin
        chk    = 7'h0;
        chk[0] = ^(data_i & 32'h2606BD25);
        chk[1] = ^(data_i & 32'hDEBA8050);
        chk[2] = ^(data_i & 32'h413D89AA);
        chk[3] = ^(data_i & 32'h31234ED1);
        chk[4] = ^(data_i & 32'hC2C1323B);
        chk[5] = ^(data_i & 32'h2DCC624C);
        chk[6] = ^(data_i & 32'h98505586);
    end

    assign data_o = {chk ^ 7'h2A, data_i};

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Ibex instruction-fetch responder backed by a word RAM, with grant stalls and error injection.
// Latency: rvalid exactly RespLatency cycles after grant, in order; one grant and one response per cycle.
// Backpressure: grant withheld at MaxOutstanding unless a response retires this cycle; rvalid cannot be stalled.
module ibex_instr_mem_responder
    import ibex_instr_mem_responder_pkg::*;
#(
    parameter int unsigned  MemWords       = 1024,
    parameter logic [31:0]  BaseAddr       = 32'h00100000,
    parameter int unsigned  RespLatency    = 1,
    parameter int unsigned  MaxOutstanding = 2,
    parameter bit           MemECC         = 1'b0,
    parameter int unsigned  MemDataWidth   = MemECC ? 39 : 32,
    localparam int unsigned IdxW           = $clog2(MemWords),
    localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [BUS_SIZE-1:0]     instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [MemDataWidth-1:0] instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    gnt_stall_i,
    input  logic                    err_inject_i,
    input  logic                    init_we_i,
    input  logic [IdxW-1:0]         init_addr_i,
    input  logic [31:0]             init_wdata_i,
    output logic [OutW-1:0]         outstanding_o
);

    localparam logic [32:0] AddrEnd = {1'b0, BaseAddr} + 33'(MemWords) * 33'd4;

    logic [31:0]             ram [MemWords];
    logic                    gnt;
    logic                    rsp_retiring;
    logic                    in_range;
    instr_rsp_t              grant_rsp;
    logic [OutW-1:0]         outstanding_q;
    logic                    fin_vld;
    instr_rsp_t              fin_rsp;
    logic                    fin_err;
    logic [31:0]             fin_word;
    logic [MemDataWidth-1:0] fin_word_enc;
    logic                    rvalid_q;
    logic                    err_q;
    logic [MemDataWidth-1:0] rdata_q;

    assign rsp_retiring = rvalid_q;
    assign gnt = rst_ni & instr_req_i & ~gnt_stall_i &
                 ((outstanding_q < OutW'(MaxOutstanding)) | rsp_retiring);

    // 33-bit upper bound so a window ending at 4 GiB does not wrap.
    assign in_range      = (instr_addr_i >= BaseAddr) & ({1'b0, instr_addr_i} < AddrEnd);
    assign grant_rsp.err = ~in_range | err_inject_i;
    assign grant_rsp.idx = instr_addr_i[BUS_SIZE-1:2] - BaseAddr[BUS_SIZE-1:2];

    if (RespLatency == 1) begin : g_no_pipe
        assign fin_vld = gnt;
        assign fin_rsp = grant_rsp;
    end else begin : g_pipe
        logic       vld_q [RespLatency-1];
        instr_rsp_t rsp_q [RespLatency-1];

        for (genvar s = 0; s < RespLatency - 1; s++) begin : g_stage
            logic       vld_d;
            instr_rsp_t rsp_d;

            if (s == 0) begin : g_head
                assign vld_d = gnt;
                assign rsp_d = grant_rsp;
            end else begin : g_tail
                assign vld_d = vld_q[s-1];
                assign rsp_d = rsp_q[s-1];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q[s] <= 1'b0;
                    rsp_q[s] <= '0;
                end else begin
                    vld_q[s] <= vld_d;
                    rsp_q[s] <= rsp_d;
                end
            end
        end

        assign fin_vld = vld_q[RespLatency-2];
        assign fin_rsp = rsp_q[RespLatency-2];
    end

    // Upper offset bits are only nonzero for out-of-range fetches, which already carry err.
    assign fin_err  = fin_rsp.err | (|fin_rsp.idx[IDX_W-1:IdxW]);
    assign fin_word = fin_err ? 32'h0 : ram[fin_rsp.idx[IdxW-1:0]];

    if (MemECC) begin : g_ecc
        logic [38:0] enc;
        prim_secded_inv_39_32_enc u_enc (
            .data_i (fin_word),
            .data_o (enc)
        );
        assign fin_word_enc = MemDataWidth'(enc);
    end else begin : g_no_ecc
        assign fin_word_enc = MemDataWidth'(fin_word);
    end

    // Write and final-stage read share an edge, so a same-index read sees the old word.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            ram[init_addr_i] <= init_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fin_vld;
            err_q    <= fin_vld & fin_err;
            if (fin_vld) begin
                rdata_q <= fin_word_enc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (gnt && !rvalid_q) begin
            outstanding_q <= outstanding_q + OutW'(1);
        end else if (!gnt && rvalid_q && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - OutW'(1);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     outstanding_q <= OutW'(MaxOutstanding));

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q;
    assign instr_err_o    = err_q;
    assign instr_rdata_o  = rdata_q;
    assign outstanding_o  = outstanding_q;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Drives two responders (latency 1 with integrity bits, latency 3 without) with shared stimulus
// and checks grants, occupancy and responses against a queue-based reference model.
module tb_ibex_instr_mem_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h00100000;
    localparam int          MAXO = 2;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] idx;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        inject;
    logic        init_we;
    logic [5:0]  init_addr;
    logic [31:0] init_wdata;

    logic        gnt_a, rvalid_a, err_a;
    logic [38:0] rdata_a;
    logic [1:0]  out_a;
    logic        gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_b;
    logic [1:0]  out_b;

    logic        gnt_v    [2];
    logic        rvalid_v [2];
    logic        err_v    [2];
    logic [38:0] rdata_v  [2];
    logic [1:0]  out_v    [2];

    exp_t        sb [2][$];
    int unsigned dq [2][$];
    logic [31:0] shadow [MW];
    logic [38:0] last_rdata [2];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_instr_mem_responder #(
        .MemWords(MW), .BaseAddr(BASE), .RespLatency(1), .MaxOutstanding(MAXO), .MemECC(1'b1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a), .instr_err_o(err_a),
        .gnt_stall_i(stall), .err_inject_i(inject), .init_we_i(init_we), .init_addr_i(init_addr),
        .init_wdata_i(init_wdata), .outstanding_o(out_a)
    );

    ibex_instr_mem_responder #(
        .MemWords(MW), .BaseAddr(BASE), .RespLatency(3), .MaxOutstanding(MAXO), .MemECC(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b), .instr_err_o(err_b),
        .gnt_stall_i(stall), .err_inject_i(inject), .init_we_i(init_we), .init_addr_i(init_addr),
        .init_wdata_i(init_wdata), .outstanding_o(out_b)
    );

    always_comb begin
        gnt_v[0]    = gnt_a;    gnt_v[1]    = gnt_b;
        rvalid_v[0] = rvalid_a; rvalid_v[1] = rvalid_b;
        err_v[0]    = err_a;    err_v[1]    = err_b;
        rdata_v[0]  = rdata_a;  rdata_v[1]  = {7'b0, rdata_b};
        out_v[0]    = out_a;    out_v[1]    = out_b;
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [38:0] ecc39(input logic [31:0] d);
        logic [31:0] m [7];
        logic [6:0]  c;
        m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
              32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
        c = 7'h0;
        for (int j = 0; j < 7; j++) c[j] = ^(d & m[j]);
        return {c ^ 7'h2A, d};
    endfunction

    function automatic logic [38:0] exp_word(input int k, input logic [31:0] d);
        return (k == 0) ? ecc39(d) : {7'b0, d};
    endfunction

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference: a request is accepted when fewer than MAXO are pending, or one is answered this cycle.
    task automatic model_step(input int k);
        int unsigned outst;
        bit          pred;
        exp_t        e;
        if (!rst_n) begin
            dq[k].delete();
            sb[k].delete();
        end
        while (dq[k].size() > 0 && dq[k][0] < cyc) void'(dq[k].pop_front());
        outst = dq[k].size();
        pred  = rst_n && req && !stall && (outst < MAXO || (outst > 0 && dq[k][0] == cyc));
        check("gnt", k, 64'(gnt_v[k]), 64'(pred));
        check("outstanding", k, 64'(out_v[k]), 64'(outst));
        if (pred) begin
            e.due  = cyc + lat(k);
            e.err  = inject || addr < BASE || addr >= BASE + 32'(4 * MW);
            e.idx  = (addr - BASE) / 4;
            e.data = 32'h0;
            dq[k].push_back(e.due);
            sb[k].push_back(e);
        end
        // Word is taken from memory as it stands one cycle before the response appears.
        for (int i = 0; i < sb[k].size(); i++) begin
            if (sb[k][i].due == cyc + 1) begin
                e      = sb[k][i];
                e.data = e.err ? 32'h0 : shadow[e.idx[5:0]];
                sb[k][i] = e;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        if (init_we) shadow[init_addr] = init_wdata;
    end

    task automatic monitor_step(input int k);
        exp_t e;
        if (!rst_n) begin
            last_rdata[k] = 39'h0;
            check("rvalid_in_reset", k, 64'(rvalid_v[k]), 64'd0);
            check("rdata_in_reset", k, 64'(rdata_v[k]), 64'd0);
            return;
        end
        if (rvalid_v[k]) begin
            if (sb[k].size() == 0) begin
                check("spurious_rvalid", k, 64'(rvalid_v[k]), 64'd0);
                return;
            end
            e = sb[k].pop_front();
            last_rdata[k] = exp_word(k, e.data);
            check("rvalid_cycle", k, 64'(cyc), 64'(e.due));
            check("err", k, 64'(err_v[k]), 64'(e.err));
            check("rdata", k, 64'(rdata_v[k]), 64'(last_rdata[k]));
        end else begin
            check("err_idle", k, 64'(err_v[k]), 64'd0);
            check("rdata_hold", k, 64'(rdata_v[k]), 64'(last_rdata[k]));
            if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                check("missing_rvalid", k, 64'(rvalid_v[k]), 64'd1);
                void'(sb[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) monitor_step(k);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0; stall = 1'b0; inject = 1'b0; init_we = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [31:0] edge_addr [3];
        int          r;
        last_rdata[0] = 39'h0;
        last_rdata[1] = 39'h0;
        rst_n = 1'b0; req = 1'b0; addr = BASE; stall = 1'b0; inject = 1'b0;
        init_we = 1'b0; init_addr = 6'd0; init_wdata = 32'h0;
        repeat (3) step();
        rst_n = 1'b1;

        for (int i = 0; i < MW; i++) begin
            init_we    = 1'b1;
            init_addr  = 6'(i);
            init_wdata = (i < 4) ? 32'(i + 1) * 32'h11 : $urandom;
            step();
        end
        init_we = 1'b0;

        // Streaming fetch of the first four words.
        for (int i = 0; i < 12; i++) begin
            req = 1'b1; addr = BASE + 32'(4 * (i % 4));
            step();
        end
        for (int i = 0; i < 12; i++) begin
            req = 1'b1; addr = BASE + 32'd16;
            step();
        end
        idle(4);

        // Just outside, just past and last word of the window.
        edge_addr[0] = BASE - 32'd4;
        edge_addr[1] = BASE + 32'(4 * MW);
        edge_addr[2] = BASE + 32'(4 * MW) - 32'd4;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; addr = edge_addr[i];
            repeat (3) step();
            idle(4);
        end

        // Error injected on the middle of three back-to-back requests.
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; addr = BASE + 32'(4 * i); inject = (i == 1);
            step();
        end
        idle(4);

        req = 1'b1; addr = BASE + 32'd12; stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (2) step();
        idle(4);

        // Backdoor write to the word being read in the same cycle.
        req = 1'b1; addr = BASE + 32'd8;
        init_we = 1'b1; init_addr = 6'd2; init_wdata = 32'hDEADBEEF;
        step();
        idle(4);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(15);
            if (r == 0) addr = BASE - 32'(4 * ($urandom_range(3) + 1));
            else if (r == 1) addr = BASE + 32'(4 * MW) + 32'(4 * $urandom_range(3));
            else addr = BASE + 32'(4 * $urandom_range(MW - 1)) + 32'($urandom_range(3));
            req        = ($urandom_range(9) < 7);
            stall      = ($urandom_range(7) == 0);
            inject     = ($urandom_range(9) == 0);
            init_we    = ($urandom_range(7) == 0);
            init_addr  = 6'($urandom_range(MW - 1));
            init_wdata = $urandom;
            step();
        end
        idle(6);

        // Reset with requests in flight, then fetch word 1 again.
        init_we = 1'b1; init_addr = 6'd1; init_wdata = 32'h22;
        step();
        init_we = 1'b0;
        req = 1'b1; addr = BASE;
        repeat (2) step();
        req = 1'b0; rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        req = 1'b1; addr = BASE + 32'd4;
        step();
        idle(12);

        for (int k = 0; k < 2; k++) check("scoreboard_drained", k, 64'(sb[k].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
